// File: rtl/ap_cam_pkg.sv
// Shared definitions for the AP CAM engine: opcodes, FSM state encoding and
// the width helper used to size address and index buses.
package ap_cam_pkg;

    // Command opcodes carried on cmd_op.
    localparam logic [2:0] OP_WRITE        = 3'd0;
    localparam logic [2:0] OP_READ         = 3'd1;
    localparam logic [2:0] OP_COMPARE      = 3'd2;
    localparam logic [2:0] OP_CMP_AND      = 3'd3;
    localparam logic [2:0] OP_CMP_OR       = 3'd4;
    localparam logic [2:0] OP_WRITE_TAGGED = 3'd5;
    localparam logic [2:0] OP_FIRST        = 3'd6;
    localparam logic [2:0] OP_TAG_FILL     = 3'd7;

    // Command sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Ceiling log2, never below 1 so that a bus always has at least one bit.
    function automatic int clogb2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/ap_cam_prio_enc.sv
// Lowest-index-wins priority encoder over an N-bit vector. Also reports
// whether any bit is set and whether more than one bit is set.
module ap_cam_prio_enc
    import ap_cam_pkg::*;
#(
    parameter  int N  = 8,
    localparam int IW = clogb2(N)
) (
    input  logic [N-1:0]  vec,
    output logic [IW-1:0] idx,
    output logic          any,
    output logic          multi
);

    // Scan upward: the first set bit fixes idx, any later set bit flags multi.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves
        // a value unassigned, which would otherwise infer a latch.
        idx   = '0;
        any   = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                if (!any) begin
                    idx = IW'(i);
                end else begin
                    multi = 1'b1;
                end
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ap_cam_engine.sv
// Associative-processor CAM engine: a CELL_QUANT x WORD_SIZE flop array with
// masked parallel compare, tag accumulation, tag-guided masked write,
// addressed read/write and first-match enumeration, driven by a
// valid/ready command channel and a back-pressured response channel.
module ap_cam_engine
    import ap_cam_pkg::*;
#(
    parameter  int WORD_SIZE  = 8,
    parameter  int CELL_QUANT = 512,
    localparam int ADDR_BITS  = clogb2(CELL_QUANT)
) (
    input  logic                  clka,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [ADDR_BITS-1:0]  cmd_addr,
    input  logic [WORD_SIZE-1:0]  cmd_data,
    input  logic [WORD_SIZE-1:0]  cmd_key,
    input  logic [WORD_SIZE-1:0]  cmd_mask,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WORD_SIZE-1:0]  rsp_data,
    output logic [ADDR_BITS-1:0]  rsp_addr,
    output logic                  rsp_hit,
    output logic                  rsp_multi,
    output logic [CELL_QUANT-1:0] tags
);

    state_t                state_q;
    state_t                state_d;
    logic                  exec;
    logic                  accept;

    // Operands latched at the handshake so the controller may move on.
    logic [2:0]            op_q;
    logic [ADDR_BITS-1:0]  addr_q;
    logic [WORD_SIZE-1:0]  data_q;
    logic [WORD_SIZE-1:0]  key_q;
    logic [WORD_SIZE-1:0]  mask_q;

    logic [CELL_QUANT-1:0] tags_q;
    logic [CELL_QUANT-1:0] tags_d;
    logic [CELL_QUANT-1:0] match;
    logic [WORD_SIZE-1:0]  cell_rd [CELL_QUANT];

    logic                  addr_ok;
    logic [WORD_SIZE-1:0]  read_word;
    logic [ADDR_BITS-1:0]  first_idx;
    logic                  first_any;
    logic                  first_multi;

    assign exec = (state_q == ST_EXEC);
    assign tags = tags_q;

    // Command sequencer state register.
    always_ff @(posedge clka) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs; ready is suppressed while in reset.
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = !rst;
                accept    = cmd_valid && !rst;
                if (accept) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Operand capture on the command handshake.
    always_ff @(posedge clka) begin
        if (rst) begin
            op_q   <= OP_WRITE;
            addr_q <= '0;
            data_q <= '0;
            key_q  <= '0;
            mask_q <= '0;
        end else if (accept) begin
            op_q   <= cmd_op;
            addr_q <= cmd_addr;
            data_q <= cmd_data;
            key_q  <= cmd_key;
            mask_q <= cmd_mask;
        end
    end

    // Cell array: one storage word and one comparator per cell.
    for (genvar i = 0; i < CELL_QUANT; i++) begin : g_cell
        logic [WORD_SIZE-1:0] cell_q;
        logic                 addr_hit;

        assign addr_hit   = (addr_q == ADDR_BITS'(i));
        assign match[i]   = (((cell_q ^ key_q) & mask_q) == '0);
        assign cell_rd[i] = cell_q;

        // Cell update: addressed write or tag-guided masked write, EXEC only.
        always_ff @(posedge clka) begin
            // NOTE: the array is flop-based and must come up all-zero, so
            // every cell is cleared by reset rather than left uninitialised.
            if (rst) begin
                cell_q <= '0;
            end else if (exec && (op_q == OP_WRITE) && addr_hit) begin
                cell_q <= data_q;
            end else if (exec && (op_q == OP_WRITE_TAGGED) && tags_q[i]) begin
                cell_q <= (cell_q & ~mask_q) | (data_q & mask_q);
            end
        end
    end

    // Lowest set tag, used by FIRST for both the response and tag clearing.
    ap_cam_prio_enc #(
        .N (CELL_QUANT)
    ) u_prio_enc (
        .vec   (tags_q),
        .idx   (first_idx),
        .any   (first_any),
        .multi (first_multi)
    );

    // Addressed read with range guard; out-of-range addresses read as zero.
    always_comb begin
        addr_ok   = (int'(addr_q) < CELL_QUANT);
        read_word = '0;
        if (addr_ok) begin
            read_word = cell_rd[addr_q];
        end
    end

    // Tag update computed during EXEC from the current tags and compare result.
    always_comb begin
        tags_d = tags_q;
        if (exec) begin
            case (op_q)
                OP_COMPARE:  tags_d = match;
                OP_CMP_AND:  tags_d = tags_q & match;
                OP_CMP_OR:   tags_d = tags_q | match;
                OP_FIRST:    if (first_any) tags_d[first_idx] = 1'b0;
                OP_TAG_FILL: tags_d = {CELL_QUANT{data_q[0]}};
                default:     tags_d = tags_q;
            endcase
        end
    end

    // Tag register.
    always_ff @(posedge clka) begin
        if (rst) begin
            tags_q <= '0;
        end else begin
            tags_q <= tags_d;
        end
    end

    // Response capture in EXEC; fields an opcode does not define read as zero.
    always_ff @(posedge clka) begin
        if (rst) begin
            rsp_data  <= '0;
            rsp_addr  <= '0;
            rsp_hit   <= 1'b0;
            rsp_multi <= 1'b0;
        end else if (exec) begin
            rsp_data  <= '0;
            rsp_addr  <= '0;
            rsp_hit   <= 1'b0;
            rsp_multi <= 1'b0;
            case (op_q)
                OP_READ: begin
                    rsp_data <= read_word;
                    rsp_hit  <= addr_ok;
                end
                OP_FIRST: begin
                    rsp_addr  <= first_idx;
                    rsp_hit   <= first_any;
                    rsp_multi <= first_multi;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ap_cam_engine.sv
// Directed self-checking bench for ap_cam_engine (CELL_QUANT = 500 so that
// out-of-range addresses exist on the 9-bit address bus).
module tb_ap_cam_engine;
    import ap_cam_pkg::*;

    localparam int WS = 8;
    localparam int CQ = 500;
    localparam int AB = 9;

    logic          clka = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = 3'd0;
    logic [AB-1:0] cmd_addr = '0;
    logic [WS-1:0] cmd_data = '0;
    logic [WS-1:0] cmd_key = '0;
    logic [WS-1:0] cmd_mask = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [WS-1:0] rsp_data;
    logic [AB-1:0] rsp_addr;
    logic          rsp_hit;
    logic          rsp_multi;
    logic [CQ-1:0] tags;

    int passed = 0;
    int total  = 0;

    logic [WS-1:0] got_data;
    logic [AB-1:0] got_addr;
    logic          got_hit;
    logic          got_multi;
    logic [CQ-1:0] got_tags;
    int            got_lat;
    logic [CQ-1:0] exp_tags;
    logic [WS-1:0] exp_word;

    ap_cam_engine #(
        .WORD_SIZE  (WS),
        .CELL_QUANT (CQ)
    ) dut (
        .clka      (clka),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .cmd_key   (cmd_key),
        .cmd_mask  (cmd_mask),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_addr  (rsp_addr),
        .rsp_hit   (rsp_hit),
        .rsp_multi (rsp_multi),
        .tags      (tags)
    );

    always #5 clka = ~clka;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Present a command and complete the handshake; returns one cycle later (EXEC).
    task automatic send_cmd(input logic [2:0] op, input logic [AB-1:0] addr,
                            input logic [WS-1:0] data, input logic [WS-1:0] key,
                            input logic [WS-1:0] mask);
        int n = 0;
        cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_key = key; cmd_mask = mask;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 20) begin
            @(posedge clka); #1; n++;
        end
        total++;
        if (!cmd_ready) $display("FAIL cmd_ready_timeout got=0 exp=1 op=%0d", op);
        else passed++;
        @(posedge clka); #1;
        cmd_valid = 1'b0;
    endtask

    // Wait for rsp_valid and capture every response field plus the tags.
    task automatic wait_rsp();
        int n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clka); #1; n++;
        end
        total++;
        if (!rsp_valid) $display("FAIL rsp_valid_timeout got=0 exp=1");
        else passed++;
        got_data = rsp_data; got_addr = rsp_addr; got_hit = rsp_hit;
        got_multi = rsp_multi; got_tags = tags; got_lat = n;
    endtask

    task automatic issue(input logic [2:0] op, input logic [AB-1:0] addr,
                         input logic [WS-1:0] data, input logic [WS-1:0] key,
                         input logic [WS-1:0] mask);
        send_cmd(op, addr, data, key, mask);
        wait_rsp();
        @(posedge clka); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clka);
        #1;
        total++; if (cmd_ready !== 1'b0) $display("FAIL rst_cmd_ready got=%b exp=0", cmd_ready); else passed++;
        total++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); else passed++;
        total++; if (tags !== '0) $display("FAIL rst_tags got=%h exp=0", tags); else passed++;
        total++; if ({rsp_data, rsp_addr, rsp_hit, rsp_multi} !== '0)
            $display("FAIL rst_rsp_fields got=%h/%h/%b/%b exp=0", rsp_data, rsp_addr, rsp_hit, rsp_multi);
        else passed++;
        rst = 1'b0;
        #1;
        total++; if (cmd_ready !== 1'b1) $display("FAIL post_rst_cmd_ready got=%b exp=1", cmd_ready); else passed++;
    endtask

    task automatic test_write_read();
        issue(OP_WRITE, 9'd3, 8'hA5, 8'h00, 8'h00);
        total++; if ({got_data, got_addr, got_hit, got_multi} !== '0)
            $display("FAIL write_rsp_zero got=%h/%h/%b/%b exp=0", got_data, got_addr, got_hit, got_multi);
        else passed++;
        issue(OP_READ, 9'd3, 8'h00, 8'h00, 8'h00);
        total++; if (got_data !== 8'hA5) $display("FAIL read3_data got=%h exp=a5", got_data); else passed++;
        total++; if (got_hit !== 1'b1) $display("FAIL read3_hit got=%b exp=1", got_hit); else passed++;
        issue(OP_READ, 9'd4, 8'h00, 8'h00, 8'h00);
        total++; if ({got_data, got_hit} !== {8'h00, 1'b1}) $display("FAIL read4 got=%h/%b exp=00/1", got_data, got_hit); else passed++;
        issue(OP_WRITE, 9'd499, 8'h77, 8'h00, 8'h00);
        issue(OP_READ, 9'd499, 8'h00, 8'h00, 8'h00);
        total++; if ({got_data, got_hit} !== {8'h77, 1'b1}) $display("FAIL read499 got=%h/%b exp=77/1", got_data, got_hit); else passed++;
        issue(OP_WRITE, 9'd510, 8'hEE, 8'h00, 8'h00);
        issue(OP_READ, 9'd510, 8'h00, 8'h00, 8'h00);
        total++; if ({got_data, got_hit} !== {8'h00, 1'b0}) $display("FAIL read510_oob got=%h/%b exp=00/0", got_data, got_hit); else passed++;
    endtask

    task automatic test_compare();
        for (int i = 0; i < 8; i++) begin
            issue(OP_WRITE, AB'(i), 8'h10 + WS'(i), 8'h00, 8'h00);
        end
        issue(OP_COMPARE, 9'd0, 8'h00, 8'h10, 8'hF8);
        exp_tags = '0; exp_tags[7:0] = 8'hFF;
        total++; if (got_tags !== exp_tags) $display("FAIL compare_tags got=%h exp=%h", got_tags, exp_tags); else passed++;
        issue(OP_CMP_AND, 9'd0, 8'h00, 8'h01, 8'h01);
        exp_tags = '0; exp_tags[7:0] = 8'hAA;
        total++; if (got_tags !== exp_tags) $display("FAIL cmp_and_tags got=%h exp=%h", got_tags, exp_tags); else passed++;
        issue(OP_CMP_OR, 9'd0, 8'h00, 8'h10, 8'hFF);
        exp_tags = '0; exp_tags[7:0] = 8'hAB;
        total++; if (got_tags !== exp_tags) $display("FAIL cmp_or_tags got=%h exp=%h", got_tags, exp_tags); else passed++;
    endtask

    task automatic test_write_tagged();
        issue(OP_CMP_AND, 9'd0, 8'h00, 8'h01, 8'h01);
        exp_tags = '0; exp_tags[7:0] = 8'hAA;
        total++; if (got_tags !== exp_tags) $display("FAIL wt_setup_tags got=%h exp=%h", got_tags, exp_tags); else passed++;
        issue(OP_WRITE_TAGGED, 9'd0, 8'hC0, 8'h00, 8'hF0);
        for (int i = 0; i < 8; i++) begin
            exp_word = (i % 2 == 1) ? (8'hC0 | WS'(i)) : (8'h10 + WS'(i));
            issue(OP_READ, AB'(i), 8'h00, 8'h00, 8'h00);
            total++; if (got_data !== exp_word) $display("FAIL wt_cell%0d got=%h exp=%h", i, got_data, exp_word); else passed++;
        end
    endtask

    task automatic test_first();
        issue(OP_WRITE, 9'd3, 8'h5A, 8'h00, 8'h00);
        issue(OP_WRITE, 9'd5, 8'h5A, 8'h00, 8'h00);
        issue(OP_COMPARE, 9'd0, 8'h00, 8'h5A, 8'hFF);
        exp_tags = '0; exp_tags[7:0] = 8'h28;
        total++; if (got_tags !== exp_tags) $display("FAIL first_setup_tags got=%h exp=%h", got_tags, exp_tags); else passed++;
        issue(OP_FIRST, 9'd0, 8'h00, 8'h00, 8'h00);
        total++; if ({got_addr, got_hit, got_multi} !== {9'd3, 1'b1, 1'b1})
            $display("FAIL first1 got=%0d/%b/%b exp=3/1/1", got_addr, got_hit, got_multi);
        else passed++;
        exp_tags = '0; exp_tags[7:0] = 8'h20;
        total++; if (got_tags !== exp_tags) $display("FAIL first1_tags got=%h exp=%h", got_tags, exp_tags); else passed++;
        issue(OP_FIRST, 9'd0, 8'h00, 8'h00, 8'h00);
        total++; if ({got_addr, got_hit, got_multi} !== {9'd5, 1'b1, 1'b0})
            $display("FAIL first2 got=%0d/%b/%b exp=5/1/0", got_addr, got_hit, got_multi);
        else passed++;
        issue(OP_FIRST, 9'd0, 8'h00, 8'h00, 8'h00);
        total++; if ({got_addr, got_hit, got_multi} !== {9'd0, 1'b0, 1'b0})
            $display("FAIL first3_empty got=%0d/%b/%b exp=0/0/0", got_addr, got_hit, got_multi);
        else passed++;
        total++; if (got_tags !== '0) $display("FAIL first_final_tags got=%h exp=0", got_tags); else passed++;
    endtask

    task automatic test_fill();
        issue(OP_COMPARE, 9'd0, 8'h00, 8'h3C, 8'h00);
        total++; if (got_tags !== {CQ{1'b1}}) $display("FAIL mask0_all_match got=%h", got_tags); else passed++;
        issue(OP_FIRST, 9'd0, 8'h00, 8'h00, 8'h00);
        exp_tags = {CQ{1'b1}}; exp_tags[0] = 1'b0;
        total++; if ({got_addr, got_hit, got_multi} !== {9'd0, 1'b1, 1'b1})
            $display("FAIL first_all got=%0d/%b/%b exp=0/1/1", got_addr, got_hit, got_multi);
        else passed++;
        total++; if (got_tags !== exp_tags) $display("FAIL first_all_tags got=%h exp=%h", got_tags, exp_tags); else passed++;
        issue(OP_TAG_FILL, 9'd0, 8'hFE, 8'h00, 8'h00);
        total++; if (got_tags !== '0) $display("FAIL fill0 got=%h exp=0", got_tags); else passed++;
        issue(OP_TAG_FILL, 9'd0, 8'h01, 8'h00, 8'h00);
        total++; if (got_tags !== {CQ{1'b1}}) $display("FAIL fill1 got=%h", got_tags); else passed++;
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        send_cmd(OP_READ, 9'd3, 8'h00, 8'h00, 8'h00);
        wait_rsp();
        total++; if (got_data !== 8'h5A) $display("FAIL bp_data got=%h exp=5a", got_data); else passed++;
        for (int c = 0; c < 5; c++) begin
            @(posedge clka); #1;
            total++; if ({rsp_valid, cmd_ready, rsp_data, rsp_hit} !== {1'b1, 1'b0, 8'h5A, 1'b1})
                $display("FAIL bp_hold%0d got=v%b r%b d%h h%b exp=v1 r0 d5a h1", c, rsp_valid, cmd_ready, rsp_data, rsp_hit);
            else passed++;
        end
        rsp_ready = 1'b1;
        @(posedge clka); #1;
        total++; if ({rsp_valid, cmd_ready} !== 2'b01) $display("FAIL bp_release got=v%b r%b exp=v0 r1", rsp_valid, cmd_ready); else passed++;
    endtask

    task automatic test_back_to_back();
        send_cmd(OP_WRITE, 9'd6, 8'h66, 8'h00, 8'h00);
        cmd_addr = 9'd7; cmd_data = 8'h99;
        wait_rsp();
        total++; if (got_lat !== 1) $display("FAIL rsp_latency got=%0d exp=1", got_lat); else passed++;
        @(posedge clka); #1;
        total++; if (cmd_ready !== 1'b1) $display("FAIL next_accept got=%b exp=1", cmd_ready); else passed++;
        issue(OP_READ, 9'd6, 8'h00, 8'h00, 8'h00);
        total++; if (got_data !== 8'h66) $display("FAIL latched_write6 got=%h exp=66", got_data); else passed++;
        issue(OP_READ, 9'd7, 8'h00, 8'h00, 8'h00);
        total++; if (got_data !== 8'hC7) $display("FAIL untouched_cell7 got=%h exp=c7", got_data); else passed++;
    endtask

    task automatic test_reset_abort();
        issue(OP_TAG_FILL, 9'd0, 8'h01, 8'h00, 8'h00);
        send_cmd(OP_WRITE, 9'd2, 8'h55, 8'h00, 8'h00);
        rst = 1'b1;
        @(posedge clka); #1;
        total++; if ({rsp_valid, cmd_ready} !== 2'b00) $display("FAIL abort_rsp got=v%b r%b exp=v0 r0", rsp_valid, cmd_ready); else passed++;
        total++; if (tags !== '0) $display("FAIL abort_tags got=%h exp=0", tags); else passed++;
        rst = 1'b0;
        @(posedge clka); #1;
        issue(OP_READ, 9'd2, 8'h00, 8'h00, 8'h00);
        total++; if ({got_data, got_hit} !== {8'h00, 1'b1}) $display("FAIL abort_read2 got=%h/%b exp=00/1", got_data, got_hit); else passed++;
        issue(OP_READ, 9'd3, 8'h00, 8'h00, 8'h00);
        total++; if (got_data !== 8'h00) $display("FAIL reset_cleared3 got=%h exp=00", got_data); else passed++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_compare();
        test_write_tagged();
        test_first();
        test_fill();
        test_backpressure();
        test_back_to_back();
        test_reset_abort();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ap_cam_engine.md
# ap_cam_engine

Parametrised associative-processor CAM engine: a CELL_QUANT × WORD_SIZE flop array with masked parallel compare, tag accumulation (AND/OR), tag-guided masked parallel write, addressed read/write, and first-match enumeration. It is the next-generation storage/match core of the AP datapath. The AP controller drives it through a single command channel with valid/ready handshaking and a response channel with back-pressure.

## Interface
Parameters:
- WORD_SIZE, 8, bits per cell.
- CELL_QUANT, 512, number of cells. Need not be a power of two; must be ≥ 2.
- ADDR_BITS, clog2(CELL_QUANT), localparam, address width.

Ports:
- clka  in  1  clock; all logic is posedge.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine can accept a command.
- cmd_op  in  3  opcode.
- cmd_addr  in  ADDR_BITS  cell address (WRITE/READ).
- cmd_data  in  WORD_SIZE  write data; bit 0 is the fill value for TAG_FILL.
- cmd_key  in  WORD_SIZE  compare key.
- cmd_mask  in  WORD_SIZE  bit mask for compare and tagged write; 1 = bit participates.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_data  out  WORD_SIZE  READ data.
- rsp_addr  out  ADDR_BITS  FIRST result index.
- rsp_hit  out  1  READ: address in range; FIRST: any tag set.
- rsp_multi  out  1  FIRST: more than one tag set.
- tags  out  CELL_QUANT  current tag register.

## Operation
Opcodes:
- 0 WRITE: mem[addr] <= data.
- 1 READ: rsp_data <= mem[addr].
- 2 COMPARE: tags[i] <= match(i).
- 3 CMP_AND: tags[i] <= tags[i] & match(i).
- 4 CMP_OR: tags[i] <= tags[i] | match(i).
- 5 WRITE_TAGGED: for every i with tags[i]=1, mem[i] <= (mem[i] & ~mask) | (data & mask). All tagged cells are written in the same cycle.
- 6 FIRST: rsp_addr <= lowest i with tags[i]=1; rsp_hit <= |tags; rsp_multi <= (popcount > 1). The reported tag bit is then cleared, which supports iteration.
- 7 TAG_FILL: tags <= {CELL_QUANT{data[0]}}.

Rules:
- match(i) = (((mem[i] ^ key) & mask) == 0). mask = 0 matches every cell.
- Address out of range (addr ≥ CELL_QUANT): WRITE has no effect. READ returns rsp_data = 0 and rsp_hit = 0. Other fields are unaffected.
- FIRST with no tags set: rsp_addr = 0, rsp_hit = 0, rsp_multi = 0. Tags are unchanged.
- Response fields not defined for an opcode are driven to 0.

FSM states:
- IDLE: cmd_ready = 1. A cmd_valid & cmd_ready handshake latches op and operands and moves to EXEC.
- EXEC: applies the memory/tag update and captures the response. Always moves to RESP.
- RESP: rsp_valid = 1; fields are held stable until rsp_ready. rsp_valid & rsp_ready moves to IDLE. Every opcode produces a response, including the write-type ops, which serves as the completion acknowledge.

Reset:
- All cells = 0, tags = 0, state = IDLE.
- cmd_ready = 0 during rst, and 1 in the first cycle after rst deasserts.
- rsp_valid, rsp_data, rsp_addr, rsp_hit, rsp_multi = 0.
- rst asserted in EXEC or RESP aborts the command with no partial update (rst has priority over the EXEC update). The pending response is discarded.

## Timing
- Handshake in cycle N. EXEC in cycle N+1, where the memory and tag update commits at the end-of-cycle edge. rsp_valid rises in N+2.
- With rsp_ready tied high, the next command is accepted in N+3. Throughput is 1 command per 3 cycles.
- tags reflects the update from cycle N+2 onward.
- READ captures mem as of the EXEC cycle, so it sees every earlier command's write.
- cmd_* inputs are ignored outside the IDLE handshake. Operands are latched, so the controller may change them after the handshake.
- Compare and priority encode are combinational within EXEC. The critical path is the CELL_QUANT-wide priority encoder; pipelining it is out of scope.

## Structure
- Package ap_cam_pkg holds:
  - opcode localparams OP_WRITE..OP_TAG_FILL (3-bit);
  - state encodings ST_IDLE, ST_EXEC, ST_RESP;
  - the clogb2 function.
- Sub-module ap_cam_prio_enc (parameter N): input vec[N]; outputs idx[clog2(N)], any, multi. Lowest index wins. Used by FIRST.
- The cell array and compare logic live in a generate loop in the top module. There is no per-cell sub-module.

## Test plan
- Reset, then WRITE addr 3 = 0xA5, then READ 3: rsp_data = 0xA5, rsp_hit = 1. READ 4 gives 0x00. With CELL_QUANT = 500, READ 510 gives rsp_hit = 0 and data 0.
- Write cells 0..7 = 0x10..0x17. COMPARE key 0x10, mask 0xF8 gives tags[7:0] = 0xFF. CMP_AND key 0x01, mask 0x01 gives 0xAA. CMP_OR key 0x10, mask 0xFF gives 0xAB.
- With tags = 0xAA, WRITE_TAGGED data 0xC0, mask 0xF0: cells 1,3,5,7 = 0xC1,0xC3,0xC5,0xC7; even cells unchanged.
- With tags = 0x28, three FIRSTs return:
  - addr 3, hit 1, multi 1;
  - addr 5, hit 1, multi 0;
  - hit 0, addr 0.
  Final tags = 0.
- Hold rsp_ready = 0 for 5 cycles after a READ: rsp_* stay stable, cmd_ready stays 0. Release rsp_ready: the next command is accepted 1 cycle later.
- Assert rst in the EXEC cycle of WRITE addr 2 = 0x55: the next cycle shows rsp_valid = 0, tags = 0. After reset, READ 2 returns 0x00.
